// File: rtl/tx_link_arbiter.sv
// tx_link_arbiter: round-robin sharing of one serial transmitter among N_REQ sources.
// Holds the granted packet on TX_Data and bounds the accept handshake with a timeout.
//
// state     | meaning
// IDLE      | nothing held; grants when TX_Ready=1 and a request is pending
// LAUNCH    | TX_Data_Valid high until TX_Ready drops or the accept timer expires
// WAIT_DONE | transmitter shifting the packet out; wait for TX_Ready to return
module tx_link_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = 55,
  parameter int ACCEPT_TIMEOUT = 16,
  localparam int IDX_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    Clk_S,
  input  logic                    Rst,
  input  logic [N_REQ-1:0]        Req_Valid,
  input  logic [N_REQ*DATA_W-1:0] Req_Data,
  output logic [N_REQ-1:0]        Req_Grant,
  input  logic                    TX_Ready,
  output logic [DATA_W-1:0]       TX_Data,
  output logic                    TX_Data_Valid,
  output logic [IDX_W-1:0]        Cur_Owner,
  output logic                    Busy,
  output logic                    Timeout_Err
);
  localparam int CNT_W = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   N_WRAP   = (IDX_W+1)'(N_REQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                terr_q, terr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W:0]      scan_idx;
  logic [DATA_W-1:0]   win_data;

  // Scan from ptr upward with wrap; the first pending index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (scan_idx >= N_WRAP) scan_idx = scan_idx - N_WRAP;
      if (!win_found && Req_Valid[scan_idx[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IDX_W-1:0];
      end
    end
    win_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win_idx == IDX_W'(i)) win_data = Req_Data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    owner_d = owner_q;
    grant_d = '0;
    valid_d = valid_q;
    terr_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (TX_Ready && win_found) begin
          data_d  = win_data;
          owner_d = win_idx;
          grant_d = N_REQ'(1) << win_idx;
          valid_d = 1'b1;
          cnt_d   = CNT_LOAD;
          ptr_d   = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // An accept on the last timer cycle still wins over the timeout.
        if (!TX_Ready) begin
          valid_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (cnt_q == '0) begin
          valid_d = 1'b0;
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (TX_Ready) state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      owner_q <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Req_Grant     = grant_q;
  assign TX_Data       = data_q;
  assign TX_Data_Valid = valid_q;
  assign Cur_Owner     = owner_q;
  assign Busy          = busy_q;
  assign Timeout_Err   = terr_q;

endmodule

// File: tb/tb_tx_link_arbiter.sv
// Bench for tx_link_arbiter: random requesters plus a transmitter stub, checked by a
// round-robin reference model feeding a scoreboard that a separate monitor drains.
module tb_tx_link_arbiter;
  localparam int N   = 4;
  localparam int DW  = 55;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            Rst;
  logic [N-1:0]    Req_Valid;
  logic [N*DW-1:0] Req_Data;
  logic [N-1:0]    Req_Grant;
  logic            TX_Ready;
  logic [DW-1:0]   TX_Data;
  logic            TX_Data_Valid;
  logic [1:0]      Cur_Owner;
  logic            Busy;
  logic            Timeout_Err;

  tx_link_arbiter #(.N_REQ(N), .DATA_W(DW), .ACCEPT_TIMEOUT(TMO)) dut (
    .Clk_S(clk), .Rst(Rst), .Req_Valid(Req_Valid), .Req_Data(Req_Data),
    .Req_Grant(Req_Grant), .TX_Ready(TX_Ready), .TX_Data(TX_Data),
    .TX_Data_Valid(TX_Data_Valid), .Cur_Owner(Cur_Owner), .Busy(Busy),
    .Timeout_Err(Timeout_Err)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [DW-1:0] data; } exp_g_t;
  typedef struct { int len; bit tmo; } exp_l_t;

  exp_g_t exp_grant[$];
  exp_l_t exp_launch[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] data [N];
  logic [N-1:0]  pend;
  int            m_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_pkt();
    return DW'({$urandom, $urandom});
  endfunction

  // Reference arbitration: first pending index at or after 'from', modulo N.
  function automatic int rr_pick(input logic [N-1:0] p, input int from);
    for (int k = 0; k < N; k++)
      if (p[(from + k) % N]) return (from + k) % N;
    return 0;
  endfunction

  task automatic drive_reqs();
    Req_Valid = pend;
    for (int i = 0; i < N; i++) Req_Data[i*DW +: DW] = data[i];
  endtask

  task automatic push_expect();
    exp_g_t e;
    int w;
    w = rr_pick(pend, m_ptr);
    e.idx  = w;
    e.data = data[w];
    exp_grant.push_back(e);
    m_ptr = (w + 1) % N;
  endtask

  task automatic check_all_zero();
    check("rst_grant",   64'(Req_Grant), 64'd0);
    check("rst_tx_data", 64'(TX_Data), 64'd0);
    check("rst_valid",   64'(TX_Data_Valid), 64'd0);
    check("rst_owner",   64'(Cur_Owner), 64'd0);
    check("rst_busy",    64'(Busy), 64'd0);
    check("rst_timeout", 64'(Timeout_Err), 64'd0);
  endtask

  // One transmitter transaction: wait for a grant, let requesters react, plan the next
  // expected grant, then accept after d extra ready cycles or let the accept time out.
  task automatic do_round(input int d, input bit tmo, input int hold,
                          input logic [N-1:0] keep, input logic [N-1:0] add,
                          input bit last, input int rst_at);
    int n;
    logic [N-1:0] g;
    logic [N-1:0] nxt;
    exp_l_t el;
    n = 0;
    while (Req_Grant == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("grant_arrives", 64'(Req_Grant != '0), 64'd1);
    if (Req_Grant == '0) return;
    g = Req_Grant;
    el.len = tmo ? TMO : d + 1;
    el.tmo = tmo;
    exp_launch.push_back(el);

    nxt = pend & ~g & keep;
    for (int i = 0; i < N; i++)
      if (add[i] && !nxt[i]) data[i] = rnd_pkt();
    pend = nxt | add;
    if (last) pend = '0;
    else if (pend == '0) begin
      n = $urandom_range(0, N-1);
      pend[n] = 1'b1;
      data[n] = rnd_pkt();
    end
    drive_reqs();
    if (!last) push_expect();

    if (tmo) begin
      @(negedge clk);
      return;
    end
    repeat (d) @(negedge clk);
    TX_Ready = 1'b0;
    if (rst_at > 0) begin
      repeat (rst_at) @(negedge clk);
      Rst = 1'b1;
      @(negedge clk);
      check_all_zero();
      exp_grant.delete();
      m_ptr = 0;
      Rst = 1'b0;
      TX_Ready = 1'b1;
      push_expect();
      @(negedge clk);
      check("grant_after_rst", 64'(Req_Grant != '0), 64'd1);
      return;
    end
    repeat (hold) @(negedge clk);
    check("busy_in_transfer", 64'(Busy), 64'd1);
    TX_Ready = 1'b1;
    @(negedge clk);
    check("busy_fall", 64'(Busy), 64'd0);
    check("no_early_grant", 64'(Req_Grant), 64'd0);
    if (!last) begin
      @(negedge clk);
      check("regrant_latency", 64'(Req_Grant != '0), 64'd1);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  bit            tracking = 1'b0;
  bit            tmo_seen = 1'b0;
  bit            have_cur = 1'b0;
  int            vcnt = 0;
  logic [DW-1:0] cur_data;
  logic [N-1:0]  want;
  exp_g_t        mg;
  exp_l_t        ml;

  always @(posedge clk) begin
    #1;
    if (Rst) begin
      tracking = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (Req_Grant != '0) begin
        check("grant_onehot", 64'($countones(Req_Grant)), 64'd1);
        check("exp_grant_avail", 64'(exp_grant.size() > 0), 64'd1);
        if (exp_grant.size() > 0) begin
          mg = exp_grant.pop_front();
          want = '0;
          want[mg.idx] = 1'b1;
          check("grant_idx", 64'(Req_Grant), 64'(want));
          check("grant_data", 64'(TX_Data), 64'(mg.data));
          check("cur_owner", 64'(Cur_Owner), 64'(mg.idx));
          cur_data = mg.data;
          have_cur = 1'b1;
        end
        tracking = 1'b1;
        vcnt = 0;
        tmo_seen = 1'b0;
      end else if (have_cur) begin
        check("tx_data_hold", 64'(TX_Data), 64'(cur_data));
      end
      if (Timeout_Err) begin
        if (tracking) tmo_seen = 1'b1;
        else check("stray_timeout", 64'(Timeout_Err), 64'd0);
      end
      if (tracking) begin
        if (TX_Data_Valid) vcnt++;
        else begin
          tracking = 1'b0;
          check("exp_launch_avail", 64'(exp_launch.size() > 0), 64'd1);
          if (exp_launch.size() > 0) begin
            ml = exp_launch.pop_front();
            check("valid_len", 64'(vcnt), 64'(ml.len));
            check("timeout_pulse", 64'(tmo_seen), 64'(ml.tmo));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b1;
    TX_Ready = 1'b1;
    pend = '1;
    for (int i = 0; i < N; i++) data[i] = DW'({16{4'(i + 5)}});
    drive_reqs();
    repeat (5) begin
      @(negedge clk);
      check_all_zero();
    end
    m_ptr = 0;
    push_expect();
    Rst = 1'b0;
    @(negedge clk);
    check("first_grant", 64'(Req_Grant), 64'b0001);
    check("first_data", 64'(TX_Data), 64'(data[0]));

    // skip over idle requesters, timeout, accept on last timer cycle, then full round-robin
    do_round(2,  1'b0, 3, 4'b0000, 4'b1001, 1'b0, 0);
    do_round(0,  1'b1, 1, 4'b0000, 4'b1001, 1'b0, 0);
    do_round(15, 1'b0, 2, 4'b0000, 4'b1111, 1'b0, 0);
    do_round(0,  1'b0, 1, 4'b1111, 4'b1111, 1'b0, 0);
    do_round(5,  1'b0, 4, 4'b1111, 4'b1111, 1'b0, 0);
    do_round(0,  1'b1, 1, 4'b1111, 4'b1111, 1'b0, 0);

    for (int r = 0; r < 40; r++) begin
      bit t;
      logic [N-1:0] km, am;
      t  = ($urandom_range(0, 4) == 0);
      km = N'($urandom);
      am = N'($urandom) & N'($urandom);
      do_round($urandom_range(0, 15), t, $urandom_range(1, 6), km, am, 1'b0, 0);
    end

    do_round($urandom_range(0, 14), 1'b0, 1, 4'b1111, 4'b0110, 1'b0, 60);

    for (int r = 0; r < 5; r++)
      do_round($urandom_range(0, 15), 1'b0, $urandom_range(1, 6), 4'b1111,
               N'($urandom), 1'b0, 0);

    do_round(2, 1'b0, 3, 4'b0000, 4'b0000, 1'b1, 0);
    repeat (6) @(negedge clk);
    check("queues_drained", 64'(exp_grant.size() + exp_launch.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
